// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin sharing of one combinational ALU between NUM_REQ
//               requesters, with a one-entry tagged response buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int NUM_REQ       = 2,
  localparam int ID_WIDTH     = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_srca,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_srcb,
  input  logic [NUM_REQ*OPCODE_LENGTH-1:0]  req_op,
  output logic [DATA_WIDTH-1:0]             alu_srca,
  output logic [DATA_WIDTH-1:0]             alu_srcb,
  output logic [OPCODE_LENGTH-1:0]          alu_op,
  input  logic [DATA_WIDTH-1:0]             alu_result,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [ID_WIDTH-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]             rsp_result
);

  localparam logic [ID_WIDTH-1:0] C_LAST_ID = ID_WIDTH'(NUM_REQ - 1);

  logic                     r_rsp_valid;
  logic [ID_WIDTH-1:0]      r_rsp_id;
  logic [DATA_WIDTH-1:0]    r_rsp_result;
  logic [ID_WIDTH-1:0]      r_last_grant;

  logic                     w_can_issue;
  logic                     w_grant_vld;
  logic [ID_WIDTH-1:0]      w_grant_id;
  logic [NUM_REQ-1:0]       w_ready;
  int                       w_scan;

  logic [DATA_WIDTH-1:0]    w_srca [NUM_REQ];
  logic [DATA_WIDTH-1:0]    w_srcb [NUM_REQ];
  logic [OPCODE_LENGTH-1:0] w_op   [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_srca[i] = req_srca[i*DATA_WIDTH +: DATA_WIDTH];
    assign w_srcb[i] = req_srcb[i*DATA_WIDTH +: DATA_WIDTH];
    assign w_op[i]   = req_op[i*OPCODE_LENGTH +: OPCODE_LENGTH];
  end

  assign w_can_issue = !r_rsp_valid || rsp_ready;

  // Scan starts one past the last winner; reset_n gating keeps req_ready low
  // while reset is held even though the buffer then reads empty.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_scan      = 0;
    if (reset_n && w_can_issue) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        w_scan = (int'(r_last_grant) + k) % NUM_REQ;
        if (!w_grant_vld && req_valid[w_scan]) begin
          w_grant_vld = 1'b1;
          w_grant_id  = w_scan[ID_WIDTH-1:0];
        end
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_grant_vld) begin
      w_ready[w_grant_id] = 1'b1;
    end
  end

  assign req_ready = w_ready;

  // Idle drive is add of zeros so the shared ALU output stays defined.
  always_comb begin
    alu_srca = '0;
    alu_srcb = '0;
    alu_op   = '0;
    if (w_grant_vld) begin
      alu_srca = w_srca[w_grant_id];
      alu_srcb = w_srcb[w_grant_id];
      alu_op   = w_op[w_grant_id];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_last_grant <= C_LAST_ID;
    end else if (w_grant_vld) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= w_grant_id;
      r_rsp_result <= alu_result;
      r_last_grant <= w_grant_id;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Directed scoreboard bench for alu_share_arbiter with a
//               behavioural ALU attached to the shared port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
  } rsp_t;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_srca;
  logic [63:0] req_srcb;
  logic [7:0]  req_op;
  logic [31:0] alu_srca;
  logic [31:0] alu_srcb;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;

  logic [31:0] a [2];
  logic [31:0] b [2];
  logic [3:0]  op [2];

  rsp_t sb[$];
  int   checks;
  int   errors;

  alu_share_arbiter #(
    .DATA_WIDTH    (32),
    .OPCODE_LENGTH (4),
    .NUM_REQ       (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_srca   (req_srca),
    .req_srcb   (req_srcb),
    .req_op     (req_op),
    .alu_srca   (alu_srca),
    .alu_srcb   (alu_srcb),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench ALU: add, sub, xor, signed set-less-than, lui; anything else is A&B.
  function automatic logic [31:0] alu_fn(input logic [31:0] x, input logic [31:0] y,
                                         input logic [3:0] o);
    case (o)
      4'b0000: return x + y;
      4'b0001: return x - y;
      4'b0100: return x ^ y;
      4'b1101: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1111: return y << 12;
      default: return x & y;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_srca, alu_srcb, alu_op);
  assign req_srca   = {a[1], a[0]};
  assign req_srcb   = {b[1], b[0]};
  assign req_op     = {op[1], op[0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, check settled outputs, then let the rising edge pass.
  task automatic step(input logic [1:0] v, input logic rr, input logic [1:0] exp_rdy);
    rsp_t e;
    int   id;
    @(negedge clk);
    req_valid = v;
    rsp_ready = rr;
    #1;
    if (sb.size() > 0) begin
      e = sb[0];
      chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
      chk("rsp_result", rsp_result, e.res);
      if (rr) e = sb.pop_front();
    end else begin
      chk("rsp_idle", {31'd0, rsp_valid}, 32'd0);
    end
    chk("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
    if (exp_rdy != 2'b00) begin
      id = exp_rdy[1] ? 1 : 0;
      chk("alu_srca", alu_srca, a[id]);
      chk("alu_op", {28'd0, alu_op}, {28'd0, op[id]});
      e.id  = exp_rdy[1];
      e.res = alu_fn(a[id], b[id], op[id]);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    a[0] = 32'd5;  b[0] = 32'd7;  op[0] = 4'b0000;
    a[1] = 32'd1;  b[1] = 32'd2;  op[1] = 4'b0000;

    // Reset held with both requesters valid
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    req_valid = 2'b00;
    @(posedge clk);
    #1;

    // First grant after reset goes to req 0: 5+7=12
    step(2'b11, 1'b1, 2'b01);
    step(2'b00, 1'b1, 2'b00);
    step(2'b00, 1'b1, 2'b00);
    chk("add_value", alu_fn(32'd5, 32'd7, 4'b0000), 32'd12);

    // lui on req 1: 0x12 << 12
    a[1] = 32'd0; b[1] = 32'h12; op[1] = 4'b1111;
    step(2'b10, 1'b1, 2'b10);

    // Round robin: sub(9,4) on req 0, xor(F0,FF) on req 1
    a[0] = 32'd9;    b[0] = 32'd4;    op[0] = 4'b0001;
    a[1] = 32'hF0;   b[1] = 32'hFF;   op[1] = 4'b0100;
    step(2'b11, 1'b1, 2'b01);
    step(2'b11, 1'b1, 2'b10);
    step(2'b11, 1'b1, 2'b01);
    step(2'b11, 1'b1, 2'b10);
    step(2'b00, 1'b1, 2'b00);
    step(2'b00, 1'b1, 2'b00);

    // Signed compare on req 0 then backpressure with req 1 waiting
    a[0] = 32'hFFFF_FFFF; b[0] = 32'd1; op[0] = 4'b1101;
    step(2'b01, 1'b1, 2'b01);
    step(2'b10, 1'b0, 2'b00);
    step(2'b10, 1'b0, 2'b00);
    step(2'b10, 1'b0, 2'b00);
    step(2'b10, 1'b1, 2'b10);
    step(2'b00, 1'b1, 2'b00);

    // Undefined opcode on req 1, result left buffered
    a[1] = 32'hF0F0; b[1] = 32'hFF00; op[1] = 4'b0110;
    step(2'b10, 1'b1, 2'b10);
    step(2'b00, 1'b0, 2'b00);

    // Reset mid-transaction: buffer drops at once, priority returns to req 0
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_req_ready", {30'd0, req_ready}, 32'd0);
    sb.delete();
    @(negedge clk);
    reset_n   = 1'b1;
    req_valid = 2'b00;
    @(posedge clk);
    #1;
    a[0] = 32'd5; b[0] = 32'd7; op[0] = 4'b0000;
    step(2'b11, 1'b1, 2'b01);
    step(2'b00, 1'b1, 2'b00);
    step(2'b00, 1'b1, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
